fp_add_arb: RTL and testbench

- Round-robin arbiter and scheduler sharing one pipelined fp_add between NREQ requesters.
- Accepts at most one operation per cycle and drives fp_add start/op_a/op_b.
- Records the issuing requester's index in an in-order tag FIFO.
- Returns each fp_add result, with a one-hot valid, to the requester that issued it; sits between the accelerator's client ports and the single adder instance.

---
 rtl/fp_arb_pkg.sv | 11 +
 rtl/rr_arb.sv | 27 ++
 rtl/fp_add_arb.sv | 113 +++++++++++
 tb/tb_fp_add_arb.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_arb_pkg.sv
// Shared constants and helpers for the fp_add arbiter slice.
package fp_arb_pkg;

    localparam int FPU_LAT      = 5;
    localparam int ISSUE_TO_RES = FPU_LAT + 2;

    function automatic int tag_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin pick: rotate so ptr+1 sits at bit 0, take the
// lowest set request, rotate the one-hot back.
module rr_arb
    import fp_arb_pkg::*;
#(
    parameter  int NREQ  = 4,
    localparam int TAG_W = tag_w(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [TAG_W-1:0] ptr,
    input  logic             en,
    output logic [NREQ-1:0]  gnt
);

    logic [TAG_W-1:0] sh;
    logic [NREQ-1:0]  rot_req;
    logic [NREQ-1:0]  rot_gnt;

    always_comb begin
        sh      = (ptr == TAG_W'(NREQ - 1)) ? '0 : ptr + TAG_W'(1);
        rot_req = NREQ'({req, req} >> sh);
        rot_gnt = rot_req & (~rot_req + NREQ'(1));
        // Right-shifting the doubled vector by NREQ-sh is a left rotate by sh.
        gnt     = en ? NREQ'({rot_gnt, rot_gnt} >> (NREQ - int'(sh))) : '0;
    end

endmodule

// File: rtl/fp_add_arb.sv
// Shares one pipelined fp_add between NREQ requesters: round-robin issue,
// in-order tag FIFO, one-hot result steering back to the issuer.
module fp_add_arb
    import fp_arb_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int NREQ         = 4,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DATA_W-1:0] op_a_in,
    input  logic [NREQ*DATA_W-1:0] op_b_in,
    output logic [NREQ-1:0]        gnt,
    output logic                   fpu_start,
    output logic [DATA_W-1:0]      fpu_op_a,
    output logic [DATA_W-1:0]      fpu_op_b,
    input  logic                   fpu_done,
    input  logic [DATA_W-1:0]      fpu_res,
    output logic [NREQ-1:0]        res_valid,
    output logic [DATA_W-1:0]      res,
    output logic                   busy,
    output logic                   err
);

    localparam int TAG_W = tag_w(NREQ);
    localparam int AW    = tag_w(MAX_INFLIGHT);
    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

    logic [TAG_W-1:0]  ptr_q, ptr_d, gnt_idx, pop_tag;
    logic [AW-1:0]     wr_q, rd_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TAG_W-1:0]  tag_mem_q [MAX_INFLIGHT];
    logic              issue_ok, grant, pop;
    logic              start_q, busy_q, err_q;
    logic [DATA_W-1:0] op_a_q, op_b_q, res_q;
    logic [NREQ-1:0]   rv_q, rv_d;

    assign issue_ok = (cnt_q < CNT_W'(MAX_INFLIGHT));
    assign grant    = |gnt;
    assign pop      = fpu_done && (cnt_q != '0);
    assign pop_tag  = tag_mem_q[rd_q];

    rr_arb #(.NREQ(NREQ)) u_rr_arb (
        .req (req),
        .ptr (ptr_q),
        .en  (issue_ok && !rst),
        .gnt (gnt)
    );

    always_comb begin
        gnt_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) gnt_idx = TAG_W'(i);
        end
        ptr_d = grant ? gnt_idx : ptr_q;

        unique case ({grant, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        rv_d = '0;
        if (pop) rv_d[pop_tag] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= TAG_W'(NREQ - 1);
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            start_q <= 1'b0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            rv_q    <= '0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            busy_q  <= (cnt_d != '0);
            start_q <= grant;
            rv_q    <= rv_d;
            if (grant) begin
                op_a_q <= op_a_in[gnt_idx*DATA_W +: DATA_W];
                op_b_q <= op_b_in[gnt_idx*DATA_W +: DATA_W];
                wr_q   <= wr_q + AW'(1);
            end
            if (pop) begin
                res_q <= fpu_res;
                rd_q  <= rd_q + AW'(1);
            end
            if (fpu_done && (cnt_q == '0)) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (grant) tag_mem_q[wr_q] <= gnt_idx;
    end

    assign fpu_start = start_q;
    assign fpu_op_a  = op_a_q;
    assign fpu_op_b  = op_b_q;
    assign res_valid = rv_q;
    assign res       = res_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_fp_add_arb.sv
// Directed bench for fp_add_arb with a 5-stage behavioural adder stand-in.
module tb_fp_add_arb;
    import fp_arb_pkg::*;

    localparam logic [31:0] ONE   = 32'h3F800000;
    localparam logic [31:0] TWO   = 32'h40000000;
    localparam logic [31:0] THREE = 32'h40400000;
    localparam logic [31:0] FOUR  = 32'h40800000;
    localparam logic [31:0] P15   = 32'h3FC00000;
    localparam logic [31:0] P25   = 32'h40200000;
    localparam logic [31:0] FILL  = 32'h41200000;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] val;
        int          due;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req, req4;
    logic [127:0] opa, opb;
    logic         spur;

    logic [3:0]  gnt0, rv0, gnt4, rv4;
    logic        st0, st4, busy0, busy4, err0, err4, done0, done4;
    logic [31:0] a0, b0, a4, b4, res0, res4;

    logic [4:0]  pv0, pv4;
    logic [31:0] pd0 [5];
    logic [31:0] pd4 [5];

    exp_t q0[$];
    exp_t q4[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    logic [3:0] et0, et4;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp_add_arb dut (
        .clk(clk), .rst(rst), .req(req), .op_a_in(opa), .op_b_in(opb),
        .gnt(gnt0), .fpu_start(st0), .fpu_op_a(a0), .fpu_op_b(b0),
        .fpu_done(done0 | spur), .fpu_res(pd0[4]), .res_valid(rv0),
        .res(res0), .busy(busy0), .err(err0)
    );

    fp_add_arb #(.MAX_INFLIGHT(4)) dut4 (
        .clk(clk), .rst(rst), .req(req4), .op_a_in(opa), .op_b_in(opb),
        .gnt(gnt4), .fpu_start(st4), .fpu_op_a(a4), .fpu_op_b(b4),
        .fpu_done(done4), .fpu_res(pd4[4]), .res_valid(rv4),
        .res(res4), .busy(busy4), .err(err4)
    );

    // Adder stand-in: positive normal operands only, truncating.
    function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] hi, lo;
        logic [24:0] mh, ml, s;
        logic [7:0]  e;
        if (x[30:23] >= y[30:23]) begin hi = x; lo = y; end
        else begin hi = y; lo = x; end
        e  = hi[30:23];
        mh = {2'b01, hi[22:0]};
        ml = {2'b01, lo[22:0]} >> (hi[30:23] - lo[30:23]);
        s  = mh + ml;
        if (s[24]) begin s = s >> 1; e = e + 8'd1; end
        return {1'b0, e, s[22:0]};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pv0 <= '0;
            pv4 <= '0;
        end else begin
            pv0 <= {pv0[3:0], st0};
            pv4 <= {pv4[3:0], st4};
            pd0[0] <= fadd(a0, b0);
            pd4[0] <= fadd(a4, b4);
            for (int i = 1; i < 5; i++) begin
                pd0[i] <= pd0[i-1];
                pd4[i] <= pd4[i-1];
            end
        end
    end
    assign done0 = pv0[4];
    assign done4 = pv4[4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic push(input int which, input logic [3:0] tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        e.due = cyc + ISSUE_TO_RES;
        if (which == 0) q0.push_back(e);
        else q4.push_back(e);
    endtask

    // Every cycle: res_valid must be exactly what the scoreboard head says is due now.
    always @(negedge clk) begin
        if (!rst) begin
            et0 = '0;
            if (q0.size() != 0 && q0[0].due == cyc) et0 = q0[0].tag;
            chk("rv0", 64'(rv0), 64'(et0));
            if (et0 != '0) begin
                chk("res0", 64'(res0), 64'(q0[0].val));
                q0.delete(0);
            end
            et4 = '0;
            if (q4.size() != 0 && q4[0].due == cyc) et4 = q4[0].tag;
            chk("rv4", 64'(rv4), 64'(et4));
            if (et4 != '0) begin
                chk("res4", 64'(res4), 64'(q4[0].val));
                q4.delete(0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int idx, input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < 4; i++) begin
            opa[i*32 +: 32] = (i == idx) ? a : FILL;
            opb[i*32 +: 32] = (i == idx) ? b : FILL;
        end
    endtask

    task automatic set_all(input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < 4; i++) begin
            opa[i*32 +: 32] = a;
            opb[i*32 +: 32] = b;
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        q0.delete();
        q4.delete();
        @(posedge clk);
        #3 rst = 1'b0;
    endtask

    task automatic drain(input int which);
        int  n;
        logic b;
        for (int i = 0; i < 40; i++) begin
            n = (which == 0) ? q0.size() : q4.size();
            b = (which == 0) ? busy0 : busy4;
            if (n == 0 && !b) break;
            @(negedge clk);
        end
        n = (which == 0) ? q0.size() : q4.size();
        b = (which == 0) ? busy0 : busy4;
        chk("drain", {31'd0, n == 0, 31'd0, b}, {31'd0, 1'b1, 31'd0, 1'b0});
    endtask

    logic [9:0] cr_pat;

    initial begin
        rst = 1'b1; req = '0; req4 = '0; spur = 1'b0; opa = '0; opb = '0;
        #2;
        chk("rst_gnt", 64'({gnt0, gnt4}), 64'(0));
        chk("rst_start", 64'({st0, st4}), 64'(0));
        chk("rst_ops", {a0, b0}, 64'(0));
        chk("rst_rv_res", {28'd0, rv0, res0}, 64'(0));
        chk("rst_busy_err", 64'({busy0, err0, busy4, err4}), 64'(0));
        #21 rst = 1'b0;

        // Single op: 1.0 + 2.0 from requester 0.
        tick(); req = 4'b0001; set_ops(0, ONE, TWO);
        @(negedge clk); chk("t1_gnt", 64'(gnt0), 64'(4'b0001)); push(0, 4'b0001, THREE);
        tick(); req = '0;
        @(negedge clk);
        chk("t1_start", 64'(st0), 64'(1));
        chk("t1_ops", {a0, b0}, {ONE, TWO});
        chk("t1_busy", 64'(busy0), 64'(1));
        tick(); @(negedge clk);
        chk("t1_start_off", 64'(st0), 64'(0));
        chk("t1_ops_hold", {a0, b0}, {ONE, TWO});
        for (int i = 3; i <= 6; i++) begin
            tick(); @(negedge clk); chk("t1_busy_mid", 64'(busy0), 64'(1));
        end
        tick(); tick(); @(negedge clk); chk("t1_busy_end", 64'(busy0), 64'(0));
        drain(0);

        // Round-robin with all four requesting continuously.
        pulse_reset();
        tick(); req = 4'b1111; set_all(P15, P25);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rr_gnt", 64'(gnt0), 64'(4'b0001 << (i % 4)));
            push(0, 4'b0001 << (i % 4), FOUR);
            tick();
        end
        req = '0;
        drain(0);

        // Mixed: requester 2 then requester 1 with distinct operands.
        tick(); req = 4'b0100; set_ops(2, ONE, ONE);
        @(negedge clk); chk("mix_gnt2", 64'(gnt0), 64'(4'b0100)); push(0, 4'b0100, TWO);
        tick(); req = 4'b0010; set_ops(1, TWO, TWO);
        @(negedge clk); chk("mix_gnt1", 64'(gnt0), 64'(4'b0010)); push(0, 4'b0010, FOUR);
        tick(); req = '0;
        drain(0);

        // Credit limit of 4: four grants, stall until the first pop, then resume.
        cr_pat = 10'b11_1000_1111;
        tick(); req4 = 4'b0001; set_ops(0, ONE, TWO);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("cr_gnt", 64'(gnt4), 64'(cr_pat[i] ? 4'b0001 : 4'b0000));
            if (cr_pat[i]) push(1, 4'b0001, THREE);
            tick();
        end
        req4 = '0;
        drain(1);

        // Async reset with three ops in flight.
        tick(); req = 4'b0001; set_ops(0, ONE, TWO);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("ar_gnt", 64'(gnt0), 64'(4'b0001)); push(0, 4'b0001, THREE);
            tick();
        end
        req = '0;
        #2 rst = 1'b1;
        q0.delete();
        q4.delete();
        #1;
        chk("ar_start", 64'(st0), 64'(0));
        chk("ar_ops", {a0, b0}, 64'(0));
        chk("ar_rv_res", {28'd0, rv0, res0}, 64'(0));
        chk("ar_busy_err", 64'({busy0, err0}), 64'(0));
        req = 4'b1111; set_all(P15, P25);
        #1 chk("ar_gnt_in_rst", 64'(gnt0), 64'(0));
        @(posedge clk); @(posedge clk);
        #3 rst = 1'b0;
        #1 chk("ar_first_gnt", 64'(gnt0), 64'(4'b0001)); push(0, 4'b0001, FOUR);
        tick(); req = '0;
        drain(0);
        chk("ar_err", 64'(err0), 64'(0));

        // Spurious done with nothing issued.
        tick(); spur = 1'b1;
        @(negedge clk); chk("sp_err_pre", 64'(err0), 64'(0));
        tick(); spur = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("sp_err", 64'(err0), 64'(1));
            chk("sp_busy", 64'(busy0), 64'(0));
            tick();
        end
        pulse_reset();
        tick(); @(negedge clk); chk("sp_err_clr", 64'(err0), 64'(0));

        chk("q_empty", 64'(q0.size() + q4.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
